// File: rtl/store_queue.sv
// Circular store queue: allocates sqNs at enqueue, drains committed stores in order
// to the LSU store port, and answers one byte-granular store-to-load forwarding lookup.
module store_queue #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned SQN_W       = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IN_enqValid,
    input  logic [29:0]        IN_enqAddr,
    input  logic [31:0]        IN_enqData,
    input  logic [3:0]         IN_enqWm,
    output logic [SQN_W-1:0]   OUT_enqSqN,
    output logic               OUT_full,
    input  logic [SQN_W-1:0]   IN_comSqN,
    input  logic               IN_branchValid,
    input  logic [SQN_W-1:0]   IN_branchSqN,
    input  logic               IN_stall,
    input  logic               IN_lookupValid,
    input  logic [29:0]        IN_lookupAddr,
    input  logic [SQN_W-1:0]   IN_lookupSqN,
    output logic [3:0]         OUT_lookupMask,
    output logic [31:0]        OUT_lookupData,
    output logic [68:0]        OUT_uopSt
);
    localparam int unsigned IDX_W  = $clog2(NUM_ENTRIES);
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WM_W   = 4;
    localparam int unsigned UOP_W  = 69;
    localparam logic [SQN_W-1:0] SQN_ONE = SQN_W'(1);

    logic [SQN_W-1:0]  head_q, head_d;
    logic [SQN_W-1:0]  tail_q, tail_d;
    logic [UOP_W-1:0]  uop_st_q, uop_st_d;
    logic [ADDR_W-1:0] ent_addr_q [NUM_ENTRIES];
    logic [ADDR_W-1:0] ent_addr_d [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_data_q [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_data_d [NUM_ENTRIES];
    logic [WM_W-1:0]   ent_wm_q   [NUM_ENTRIES];
    logic [WM_W-1:0]   ent_wm_d   [NUM_ENTRIES];

    logic [SQN_W-1:0]  count_c;
    logic [SQN_W-1:0]  flush_tail_c;
    logic [IDX_W-1:0]  head_idx_c;
    logic [IDX_W-1:0]  tail_idx_c;
    logic              enq_c;
    logic              drain_c;
    logic [SQN_W-1:0]  scan_sqn_c;
    logic [IDX_W-1:0]  scan_idx_c;

    // a is older than b when the wrapped difference a - b is negative
    function automatic logic older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return diff[SQN_W-1];
    endfunction

    assign count_c      = tail_q - head_q;
    assign OUT_full     = (count_c == SQN_W'(NUM_ENTRIES));
    assign OUT_enqSqN   = tail_q;
    assign OUT_uopSt    = uop_st_q;
    assign head_idx_c   = head_q[IDX_W-1:0];
    assign tail_idx_c   = tail_q[IDX_W-1:0];
    assign flush_tail_c = IN_branchSqN + SQN_ONE;
    assign enq_c        = IN_enqValid && !OUT_full && !IN_branchValid;
    assign drain_c      = (count_c != '0) && older(head_q, IN_comSqN) && !IN_stall;

    // Next state: drain at head, then either flush-rewind or enqueue at tail
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        uop_st_d   = '0;
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_wm_d   = ent_wm_q;
        if (drain_c) begin
            uop_st_d = {ent_addr_q[head_idx_c], 2'b00, ent_data_q[head_idx_c],
                        ent_wm_q[head_idx_c], 1'b1};
            head_d   = head_q + SQN_ONE;
        end
        if (IN_branchValid) begin
            if (older(flush_tail_c, tail_q)) begin
                tail_d = flush_tail_c;
            end
        end else if (enq_c) begin
            ent_addr_d[tail_idx_c] = IN_enqAddr;
            ent_data_d[tail_idx_c] = IN_enqData;
            ent_wm_d[tail_idx_c]   = IN_enqWm;
            tail_d                 = tail_q + SQN_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            uop_st_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            uop_st_q <= uop_st_d;
        end
    end

    // Entry payloads need no reset: validity comes from the head/tail window
    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_wm_q   <= ent_wm_d;
    end

    // Forwarding: outgoing store is oldest, then scan queue oldest to youngest
    always_comb begin
        OUT_lookupMask = '0;
        OUT_lookupData = '0;
        scan_sqn_c     = '0;
        scan_idx_c     = '0;
        if (IN_lookupValid) begin
            if (uop_st_q[0] && (uop_st_q[68:39] == IN_lookupAddr)) begin
                OUT_lookupMask = uop_st_q[4:1];
                OUT_lookupData = uop_st_q[36:5];
            end
            for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
                scan_sqn_c = head_q + SQN_W'(k);
                scan_idx_c = scan_sqn_c[IDX_W-1:0];
                if ((SQN_W'(k) < count_c) && older(scan_sqn_c, IN_lookupSqN) &&
                    (ent_addr_q[scan_idx_c] == IN_lookupAddr)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ent_wm_q[scan_idx_c][b]) begin
                            OUT_lookupMask[b]         = 1'b1;
                            OUT_lookupData[8*b +: 8]  = ent_data_q[scan_idx_c][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(IN_enqValid && OUT_full && !IN_branchValid))
                else $warning("store_queue: enqueue while full was dropped");
            assert (!IN_branchValid ||
                    !older(IN_branchSqN + SQN_ONE, head_q))
                else $error("store_queue: flush would remove committed stores");
        end
    end
`endif

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue with a queue-based reference model checked every cycle.
module tb_store_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic [29:0] enq_addr;
    logic [31:0] enq_data;
    logic [3:0]  enq_wm;
    logic [6:0]  enq_sqn;
    logic        full;
    logic [6:0]  com_sqn;
    logic        branch_valid;
    logic [6:0]  branch_sqn;
    logic        stall;
    logic        lookup_valid;
    logic [29:0] lookup_addr;
    logic [6:0]  lookup_sqn;
    logic [3:0]  lk_mask;
    logic [31:0] lk_data;
    logic [68:0] uop_st;

    store_queue #(.NUM_ENTRIES(8), .SQN_W(7)) dut (
        .clk(clk), .rst(rst),
        .IN_enqValid(enq_valid), .IN_enqAddr(enq_addr), .IN_enqData(enq_data),
        .IN_enqWm(enq_wm), .OUT_enqSqN(enq_sqn), .OUT_full(full),
        .IN_comSqN(com_sqn), .IN_branchValid(branch_valid), .IN_branchSqN(branch_sqn),
        .IN_stall(stall), .IN_lookupValid(lookup_valid), .IN_lookupAddr(lookup_addr),
        .IN_lookupSqN(lookup_sqn), .OUT_lookupMask(lk_mask), .OUT_lookupData(lk_data),
        .OUT_uopSt(uop_st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  sqn;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  wm;
    } st_t;

    st_t q[$];
    st_t m_u;
    bit  m_uv = 0;
    int  m_tail = 0;
    bit  chk_en = 0;
    int  n_checks = 0;
    int  n_err = 0;
    int  drained = 0;

    function automatic int sdiff(input int a, input int b);
        int d;
        d = (a - b) & 127;
        if (d >= 64) d -= 128;
        return d;
    endfunction

    task automatic check(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of in-flight stores plus the outgoing store
    always @(posedge clk) begin : model
        st_t e;
        bit  full_pre;
        bit  drain;
        if (rst) begin
            q.delete();
            m_tail = 0;
            m_uv   = 0;
            chk_en = 1;
        end else begin
            full_pre = (q.size() == 8);
            drain    = (q.size() != 0) && (sdiff(q[0].sqn, com_sqn) < 0) && !stall;
            m_uv     = drain;
            if (drain) begin
                m_u = q[0];
                void'(q.pop_front());
            end
            if (branch_valid) begin
                while (q.size() != 0 && sdiff(q[$].sqn, branch_sqn) > 0) void'(q.pop_back());
                if (sdiff(int'(branch_sqn) + 1, m_tail) < 0) m_tail = (int'(branch_sqn) + 1) % 128;
            end else if (enq_valid && !full_pre) begin
                e.sqn  = 7'(m_tail);
                e.addr = enq_addr;
                e.data = enq_data;
                e.wm   = enq_wm;
                q.push_back(e);
                m_tail = (m_tail + 1) % 128;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin : compare
        logic [3:0]  em;
        logic [31:0] ed;
        logic [31:0] bm;
        if (chk_en) begin
            check("enq_sqn", 69'(enq_sqn), 69'(m_tail));
            check("full", 69'(full), 69'(q.size() == 8));
            check("uop_valid", 69'(uop_st[0]), 69'(m_uv));
            if (m_uv) check("uop", uop_st, {m_u.addr, 2'b00, m_u.data, m_u.wm, 1'b1});
            if (uop_st[0]) drained++;
            em = '0;
            ed = '0;
            if (lookup_valid) begin
                if (m_uv && m_u.addr == lookup_addr) begin
                    em = m_u.wm;
                    ed = m_u.data;
                end
                foreach (q[i]) begin
                    if (sdiff(q[i].sqn, lookup_sqn) < 0 && q[i].addr == lookup_addr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (q[i].wm[b]) begin
                                em[b] = 1'b1;
                                ed[8*b +: 8] = q[i].data[8*b +: 8];
                            end
                        end
                    end
                end
            end
            bm = {{8{em[3]}}, {8{em[2]}}, {8{em[1]}}, {8{em[0]}}};
            check("lk_mask", 69'(lk_mask), 69'(em));
            check("lk_data", 69'(lk_data & bm), 69'(ed & bm));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid    = 0;
        branch_valid = 0;
        stall        = 0;
        lookup_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        com_sqn = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic enq(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
        enq_valid = 1;
        enq_addr  = a;
        enq_data  = d;
        enq_wm    = w;
    endtask

    task automatic look(input logic [29:0] a, input logic [6:0] s);
        lookup_valid = 1;
        lookup_addr  = a;
        lookup_sqn   = s;
        #1;
    endtask

    int sent;
    int com;
    int base;

    initial begin
        enq_addr = 0; enq_data = 0; enq_wm = 0; branch_sqn = 0;
        lookup_addr = 0; lookup_sqn = 0;

        // Reset state
        do_reset();
        look(30'h0, 7'd0);
        check("rst_uop_valid", 69'(uop_st[0]), 69'(0));
        check("rst_full", 69'(full), 69'(0));
        check("rst_enq_sqn", 69'(enq_sqn), 69'(0));
        check("rst_lk_mask", 69'(lk_mask), 69'(0));

        // Single store, commit, drain one cycle later
        idle();
        enq(30'h10, 32'hAABBCCDD, 4'hF);
        #1 check("t1_sqn0", 69'(enq_sqn), 69'(0));
        step();
        enq_valid = 0;
        com_sqn = 7'd1;
        #1 check("t1_no_uop_yet", 69'(uop_st[0]), 69'(0));
        step();
        check("t1_uop_valid", 69'(uop_st[0]), 69'(1));
        check("t1_uop_addr", 69'(uop_st[68:39]), 69'(30'h10));
        check("t1_uop_pad", 69'(uop_st[38:37]), 69'(0));
        check("t1_uop_data", 69'(uop_st[36:5]), 69'(32'hAABBCCDD));
        check("t1_uop_wm", 69'(uop_st[4:1]), 69'(4'hF));
        look(30'h10, 7'd5);
        check("t1_fwd_from_uop", 69'(lk_mask), 69'(4'hF));
        step();
        #1 check("t1_gone_mask", 69'(lk_mask), 69'(0));
        check("t1_uop_cleared", 69'(uop_st[0]), 69'(0));

        // Fill, overflow drop, in-order drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            enq(30'h100 + 30'(i), 32'h1000_0000 + 32'(i), 4'hF);
            step();
        end
        #1 check("t2_full", 69'(full), 69'(1));
        enq(30'h1FF, 32'hFFFF_FFFF, 4'hF);
        step();
        enq_valid = 0;
        com_sqn = 7'd8;
        #1 check("t2_drop_sqn", 69'(enq_sqn), 69'(8));
        check("t2_still_full", 69'(full), 69'(1));
        for (int i = 0; i < 8; i++) begin
            step();
            check("t2_drain_valid", 69'(uop_st[0]), 69'(1));
            check("t2_drain_addr", 69'(uop_st[68:39]), 69'(30'h100 + 30'(i)));
            if (i == 0) check("t2_full_drop", 69'(full), 69'(0));
        end
        step();
        check("t2_drain_done", 69'(uop_st[0]), 69'(0));

        // Byte-granular forwarding, youngest older store wins per byte
        do_reset();
        enq(30'h20, 32'h0000_1122, 4'b0011);
        step();
        enq(30'h20, 32'h0033_4400, 4'b0110);
        step();
        enq_valid = 0;
        look(30'h20, 7'd2);
        check("t3_mask_sqn2", 69'(lk_mask), 69'(4'b0111));
        check("t3_data_sqn2", 69'(lk_data[23:0]), 69'(24'h334422));
        look(30'h20, 7'd1);
        check("t3_mask_sqn1", 69'(lk_mask), 69'(4'b0011));
        check("t3_data_sqn1", 69'(lk_data[15:0]), 69'(16'h1122));
        look(30'h20, 7'd0);
        check("t3_mask_sqn0", 69'(lk_mask), 69'(0));
        lookup_valid = 0;
        #1 check("t3_mask_novalid", 69'(lk_mask), 69'(0));
        com_sqn = 7'd1;
        step();
        check("t3_uop_valid", 69'(uop_st[0]), 69'(1));
        look(30'h20, 7'd2);
        check("t3_uop_mask_sqn2", 69'(lk_mask), 69'(4'b0111));
        check("t3_uop_data_sqn2", 69'(lk_data[23:0]), 69'(24'h334422));
        look(30'h20, 7'd1);
        check("t3_uop_mask_sqn1", 69'(lk_mask), 69'(4'b0011));
        check("t3_uop_data_sqn1", 69'(lk_data[15:0]), 69'(16'h1122));
        step();

        // Misprediction flush
        do_reset();
        for (int i = 0; i < 5; i++) begin
            enq(30'h40 + 30'(i), 32'h4000_0000 + 32'(i), 4'hF);
            step();
        end
        enq(30'h99, 32'h9999_9999, 4'hF);
        branch_valid = 1;
        branch_sqn = 7'd1;
        step();
        idle();
        #1 check("t4_tail", 69'(enq_sqn), 69'(2));
        look(30'h43, 7'd10);
        check("t4_flushed_mask", 69'(lk_mask), 69'(0));
        look(30'h41, 7'd10);
        check("t4_kept_mask", 69'(lk_mask), 69'(4'hF));
        check("t4_kept_data", 69'(lk_data), 69'(32'h4000_0001));
        look(30'h99, 7'd10);
        check("t4_suppressed_enq", 69'(lk_mask), 69'(0));
        lookup_valid = 0;
        branch_valid = 1;
        branch_sqn = 7'd6;
        step();
        branch_valid = 0;
        #1 check("t4_tail_unchanged", 69'(enq_sqn), 69'(2));
        enq(30'h43, 32'hDEAD_0043, 4'hF);
        step();
        enq_valid = 0;
        #1 check("t4_new_tail", 69'(enq_sqn), 69'(3));
        look(30'h43, 7'd10);
        check("t4_new_data", 69'(lk_data), 69'(32'hDEAD_0043));
        step();

        // Long run with random stalls; sqN wraps past 127
        do_reset();
        sent = 0;
        com  = 0;
        base = drained;
        for (int cyc = 0; sent < 200 && cyc < 3000; cyc++) begin
            enq_valid = 0;
            if (q.size() < 8 && $urandom_range(0, 3) != 0) begin
                enq(30'h200 + 30'(sent % 5), $urandom, 4'($urandom_range(1, 15)));
                sent++;
            end
            if (com < sent && $urandom_range(0, 1) == 1) com++;
            com_sqn      = 7'(com % 128);
            stall        = ($urandom_range(0, 2) == 0);
            lookup_valid = 1;
            lookup_addr  = 30'h200 + 30'($urandom_range(0, 4));
            lookup_sqn   = 7'((sent + 128 - $urandom_range(0, 5)) % 128);
            step();
        end
        idle();
        com_sqn = 7'(sent % 128);
        for (int w = 0; w < 40 && (q.size() != 0 || m_uv); w++) step();
        step();
        check("t5_sent", 69'(sent), 69'(200));
        check("t5_drained", 69'(drained - base), 69'(200));
        check("t5_tail_wrapped", 69'(enq_sqn), 69'(72));
        check("t5_not_full", 69'(full), 69'(0));

        // Reset in the middle of operation with a drain pending
        do_reset();
        for (int i = 0; i < 5; i++) begin
            enq(30'h300 + 30'(i), 32'h3000_0000 + 32'(i), 4'hF);
            step();
        end
        enq_valid = 0;
        com_sqn = 7'd5;
        rst = 1;
        step();
        rst = 0;
        look(30'h300, 7'd10);
        check("t6_uop_valid", 69'(uop_st[0]), 69'(0));
        check("t6_enq_sqn", 69'(enq_sqn), 69'(0));
        check("t6_full", 69'(full), 69'(0));
        check("t6_lk_mask", 69'(lk_mask), 69'(0));
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
Circular buffer of in-flight stores that sits directly upstream of the load/store unit. It allocates a store sequence number (sqN) to each store at enqueue and holds the entry until commit. Committed stores drain in order, one per cycle, into the LSU store port. Each cycle it also answers one combinational forwarding lookup, giving the LSU byte-granular data from older, not-yet-written stores.

Parameters:
NUM_ENTRIES, 8, queue depth; power of two, at most 64
SQN_W, 7, sqN width; wraps modulo 2^SQN_W and is compared with signed difference

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
IN_enqValid  in  1  enqueue one store this cycle
IN_enqAddr  in  30  word address
IN_enqData  in  32  store data, already byte-lane aligned
IN_enqWm  in  4  byte write mask, bit i = byte i
OUT_enqSqN  out  SQN_W  sqN that an enqueue this cycle receives (= tail sqN)
OUT_full  out  1  no free slot; upstream must not enqueue while high
IN_comSqN  in  SQN_W  stores with signed(sqN - IN_comSqN) < 0 are committed
IN_branchValid  in  1  misprediction flush
IN_branchSqN  in  SQN_W  youngest surviving store sqN
IN_stall  in  1  LSU cannot accept a store this cycle
IN_lookupValid  in  1  load lookup request
IN_lookupAddr  in  30  load word address
IN_lookupSqN  in  SQN_W  stores with signed(sqN - IN_lookupSqN) < 0 are older than the load
OUT_lookupMask  out  4  bytes supplied by forwarding
OUT_lookupData  out  32  forwarded bytes; lanes outside the mask are don't-care
OUT_uopSt  out  69  {addr[68:39], 2'b0 [38:37], data[36:5], wm[4:1], valid[0]}

Behaviour:
- Reset:
  - head and tail sqN are 0; all entries are invalid.
  - OUT_uopSt[0] = 0, OUT_full = 0, OUT_enqSqN = 0.
  - The lookup outputs are combinational and read 0 when there are no entries.
- Occupancy:
  - Entry index = sqN[log2(NUM_ENTRIES)-1:0]; count = tail - head, computed modulo 2^SQN_W.
  - OUT_full = (count == NUM_ENTRIES), computed from registered state.
- Enqueue: when IN_enqValid && !OUT_full && !IN_branchValid, write the entry at the tail and increment tail. An enqueue while full is dropped and a simulation assertion fires.
- Drain:
  - The head entry is eligible when count != 0, signed(headSqN - IN_comSqN) < 0, and !IN_stall.
  - When eligible, OUT_uopSt is registered on the next edge with valid=1, and head increments.
  - Otherwise OUT_uopSt valid=0 on the next edge.
  - Store-to-LSU latency is 1 cycle. Throughput is 1 per cycle.
- Same-cycle enqueue and drain is allowed when not full; count is unchanged.
- Flush:
  - On IN_branchValid, tail <= IN_branchSqN + 1 if signed(IN_branchSqN + 1 - tail) < 0; otherwise tail is unchanged.
  - Committed entries are never flushed; an assertion requires signed(IN_branchSqN + 1 - head) >= 0.
  - A drain in the same cycle still proceeds.
  - Enqueue is suppressed in the flush cycle.
- Lookup (combinational, same cycle as the request):
  - Candidates are valid entries older than IN_lookupSqN with addr == IN_lookupAddr, plus the OUT_uopSt register when valid with a matching addr.
  - The OUT_uopSt register is the oldest candidate, because it is being written to memory this very cycle.
  - Scan oldest to youngest. Each matching byte lane overwrites the data and sets its mask bit, so the youngest older store wins per byte.
  - When IN_lookupValid = 0: mask = 0.
- sqN wrap-around: all age comparisons use the signed SQN_W-bit difference. This is correct while count <= NUM_ENTRIES < 2^(SQN_W-1).
- Reset mid-operation: all entries are dropped the next cycle and no store is emitted.

Test Plan:
- Enqueue addr 0x10, data 0xAABBCCDD, wm 4'b1111, then set IN_comSqN=1 -> OUT_enqSqN was 0; one cycle later OUT_uopSt valid, addr 0x10, data 0xAABBCCDD, wm 4'hF; count returns to 0.
- Fill 8 stores with IN_comSqN=0 -> OUT_full=1 after the 8th; a 9th IN_enqValid is dropped (assertion); set IN_comSqN=8 -> 8 drains on consecutive cycles in sqN order 0..7; OUT_full drops after the first drain.
- Store sqN0 addr 0x20 wm 4'b0011 data 0x____1122, store sqN1 addr 0x20 wm 4'b0110 data 0x__3344__; lookup addr 0x20, IN_lookupSqN=2 -> mask 4'b0111, data[23:0] = 0x334422; with IN_lookupSqN=1 -> mask 4'b0011, data[15:0] = 0x1122.
- Enqueue sqN0..4, branch with IN_branchSqN=1 -> tail = 2, OUT_enqSqN = 2; a lookup with IN_lookupSqN=10 matching the flushed sqN3 address returns mask 0.
- Run 200 stores through with random IN_stall so sqN wraps past 127 -> drain order and forwarding stay correct across the wrap (sqN 127 is older than sqN 0).
- Assert rst with 5 entries queued and a drain pending -> next cycle OUT_uopSt valid = 0, OUT_enqSqN = 0, OUT_full = 0, lookup mask = 0.
